univ_shift_reg_ext: RTL
=======================

// Module: univ_shift_reg_ext
// PURPOSE
//  Parametrised universal shift register, next generation. Adds multi-bit shift
//  amounts, rotates, arithmetic right shift and an autonomous LSB-first serialize
//  mode with busy/done handshake. Sits in datapaths and serial-link front ends
//  that need one register for load, shift and serial transmit.
// PARAMETERS
//  N      8  register width in bits (N >= 2)
//  AMT_W  3  width of the shift-amount input
// PORTS
//  clk      in   1      rising-edge clock
//  reset_n  in   1      asynchronous, active-low reset
//  clr      in   1      synchronous clear, highest synchronous priority
//  en       in   1      operation strobe; sampled only when busy=0
//  op       in   3      operation code (see BEHAVIOUR)
//  amt      in   AMT_W  shift/rotate amount
//  msb_in   in   1      fill bit for right shifts and serialize
//  lsb_in   in   1      fill bit for left shifts
//  d        in   N      parallel load / serialize data
//  q        out  N      register contents (registered)
//  ser_out  out  1      serial bit; q[0] while busy=1, else 0
//  busy     out  1      high while serialize is in progress
//  done     out  1      one-cycle pulse when serialize completes
// BEHAVIOUR
//  Reset (reset_n=0, async): q=0, busy=0, done=0, FSM=IDLE, bit counter=0.
//  Priority per edge: clr > accepted op > hold. clr has the same effect as reset,
//  applied synchronously; it aborts a serialize with no done pulse.
//  op codes (accepted when en=1 and busy=0; result visible in q one cycle later):
//   000 HOLD  q unchanged
//   001 SHR   q >> amt, vacated MSBs filled with msb_in
//   010 SHL   q << amt, vacated LSBs filled with lsb_in
//   011 LOAD  q <= d
//   100 ROR   rotate right by amt mod N
//   101 ROL   rotate left by amt mod N
//   110 ASR   q >> amt, vacated MSBs filled with q[N-1]
//   111 SER   start serialize
//  amt=0 leaves q unchanged for ops 001,010,100,101,110.
//  For SHR/SHL/ASR, amt>=N gives a word made entirely of fill bits.
//  en=0 holds q. While busy=1, en and op are ignored: requests are dropped, not queued.
//  FSM IDLE/SHIFT:
//   IDLE -> SHIFT on accepted SER: q<=d, cnt<=N-1, busy<=1.
//   In SHIFT, every edge: q <= {msb_in, q[N-1:1]}.
//    cnt!=0: cnt<=cnt-1.
//    cnt==0: go to IDLE, busy<=0, done<=1.
//  busy is high for exactly N cycles. During the k-th busy cycle (k=0..N-1),
//  ser_out = d[k]. done is high the cycle after the last busy cycle, and is 0
//  in every other cycle. After completion, q holds the N msb_in samples taken
//  during the shifts.
//  A new SER may be accepted in the same cycle done=1, because busy=0 then.
//  Reset or clr mid-serialize: immediate return to IDLE, q=0, no done pulse.
//  All outputs are registered except ser_out, which is the gated q[0].
// TESTING  (N=8, AMT_W=3)
//  Reset -> q=8'h00, busy=0, done=0, ser_out=0. Then LOAD d=8'hA5 -> q=8'hA5 next cycle.
//  q=8'hA5, SHR amt=3, msb_in=1 -> q=8'hF4. q=8'hA5, SHL amt=1, lsb_in=1 -> q=8'h4B.
//  q=8'hA5: ROL amt=3 -> 8'h2D; ROR amt=3 -> 8'hB4. q=8'h96, ASR amt=2 -> 8'hE5.
//  SER d=8'hB4, msb_in=0 -> ser_out=0,0,1,0,1,1,0,1 over 8 busy cycles, done pulse
//   in cycle 9, final q=8'h00. A LOAD issued in busy cycle 3 is ignored.
//  SER d=8'hFF, reset_n pulsed low in busy cycle 4 -> q=0, busy=0, done never
//   asserts. Repeat with clr=1 -> identical result.
//  SER back-to-back: second SER issued in the done cycle -> busy is 0 for one
//   cycle only, then the second stream starts.

Source files
------------

// File: rtl/univ_shift_reg_ext.sv
// Universal shift register: load, shift, rotate, arithmetic shift, LSB-first serialize.
// Latency: one cycle from accepted op to q; serialize runs N cycles then pulses done.
// Backpressure: busy=1 drops en/op requests (not queued); clr overrides everything.
module univ_shift_reg_ext #(
   parameter int N     = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic             msb_in,
   input  logic             lsb_in,
   input  logic [N-1:0]     d,
   output logic [N-1:0]     q,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_SHR  = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_LOAD = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;
   localparam logic [2:0] OP_ROL  = 3'b101;
   localparam logic [2:0] OP_ASR  = 3'b110;
   localparam logic [2:0] OP_SER  = 3'b111;

   localparam logic [N-1:0] ALL_ONES = '1;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [N-1:0]     q_nx;
   logic             busy_nx;
   logic             done_nx;

   logic [31:0]      rot_amt;
   logic [N-1:0]     shr_res;
   logic [N-1:0]     shl_res;
   logic [N-1:0]     asr_res;
   logic [N-1:0]     ror_res;
   logic [N-1:0]     rol_res;

   // Shift/rotate results; a mask of vacated positions supplies the fill bits,
   // and shifting by >= N empties the word so amt >= N yields all fill bits.
   always_comb begin
      rot_amt = 32'(amt) % N;
      shr_res = (q >> amt) | (msb_in ? ~(ALL_ONES >> amt) : '0);
      shl_res = (q << amt) | (lsb_in ? ~(ALL_ONES << amt) : '0);
      asr_res = (q >> amt) | (q[N-1] ? ~(ALL_ONES >> amt) : '0);
      // A rotate of 0 shifts the complementary term by N, which contributes nothing.
      ror_res = (q >> rot_amt) | (q << (N - rot_amt));
      rol_res = (q << rot_amt) | (q >> (N - rot_amt));
   end

   // Next-state logic: clr first, then accepted op in IDLE, or one serial shift per cycle.
   always_comb begin
      state_nx = state;
      q_nx     = q;
      cnt_nx   = cnt;
      done_nx  = 1'b0;
      if (clr) begin
         state_nx = IDLE;
         q_nx     = '0;
         cnt_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  case (op)
                     OP_SHR:  q_nx = shr_res;
                     OP_SHL:  q_nx = shl_res;
                     OP_LOAD: q_nx = d;
                     OP_ROR:  q_nx = ror_res;
                     OP_ROL:  q_nx = rol_res;
                     OP_ASR:  q_nx = asr_res;
                     OP_SER: begin
                        q_nx     = d;
                        cnt_nx   = CNT_W'(N - 1);
                        state_nx = SHIFT;
                     end
                     OP_HOLD: q_nx = q;
                     default: q_nx = q;
                  endcase
               end
            end
            SHIFT: begin
               q_nx = {msb_in, q[N-1:1]};
               if (cnt != '0) begin
                  cnt_nx = cnt - CNT_W'(1);
               end else begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
      busy_nx = (state_nx == SHIFT);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         q     <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         q     <= q_nx;
         cnt   <= cnt_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

   // Serial output is only meaningful while a stream is in flight.
   always_comb begin
      ser_out = busy ? q[0] : 1'b0;
   end

endmodule
